// File: rtl/rfs_dim_capture_pkg.sv
// Shared constants and types for the frame-dimension capture controller.
package rfs_dim_capture_pkg;

  localparam logic [1:0] ADDR_SNAP   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CNT    = 2'd3;

  localparam int unsigned ST_VALID   = 0;
  localparam int unsigned ST_CHANGED = 1;
  localparam int unsigned ST_BUSY    = 2;

  localparam int unsigned CT_ENABLE  = 0;
  localparam int unsigned CT_FREEZE  = 1;
  localparam int unsigned CT_IRQ_EN  = 2;

  typedef enum logic [1:0] {IDLE, TRACK, COMMIT, HOLD} state_t;

endpackage

// File: rtl/rfs_dim_capture_if.sv
// Avalon-MM register bus between the Nios master and the capture controller.
interface rfs_dim_capture_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/rfs_stable_filter.sv
// Holds the last sampled {height,width} and counts consecutive identical samples,
// saturating at STABLE_CYCLES-1; stable flags a match at the saturated count.
module rfs_stable_filter #(
  parameter int unsigned DW            = 12,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [2*DW-1:0]   cur,
  output logic [2*DW-1:0]   prev,
  output logic [CNT_W-1:0]  cnt,
  output logic              diff,
  output logic              stable
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  assign diff   = (cur != prev);
  assign stable = !diff && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt  <= '0;
    end else if (load || diff) begin
      prev <= cur;
      cnt  <= '0;
    end else if (cnt != LAST) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rfs_dim_capture_ctrl.sv
// Stable-filtered width/height snapshot with Avalon-MM status/control registers.
// Optional irq output and CTRL irq_en bit are built when RFS_DIM_CAPTURE_IRQ_EN is defined.
module rfs_dim_capture_ctrl
  import rfs_dim_capture_pkg::*;
#(
  parameter int unsigned DW            = 12,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                clk,
  input  logic                reset,
  rfs_dim_capture_if.slave    bus,
  input  logic [DW-1:0]       in_width,
  input  logic [DW-1:0]       in_height
`ifdef RFS_DIM_CAPTURE_IRQ_EN
  ,
  output logic                irq
`endif
);

  state_t            state, state_n;
  logic              enable, freeze, valid, changed, irq_en;
  logic [DW-1:0]     snap_w, snap_h;
  logic [2*DW-1:0]   prev;
  logic [CNT_W-1:0]  cnt;
  logic              diff, stable, commit, changed_set, w1c, ctrl_wr;
  logic [31:0]       rd_mux;
  logic              unused_bus;

  rfs_stable_filter #(
    .DW            (DW),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .clr    (!enable),
    .load   (state == IDLE),
    .cur    ({in_height, in_width}),
    .prev   (prev),
    .cnt    (cnt),
    .diff   (diff),
    .stable (stable)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // A change during COMMIT restarts tracking so the new value is not stranded in HOLD.
  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_n = TRACK;
        TRACK:   if (stable) state_n = COMMIT;
        COMMIT:  state_n = diff ? TRACK : HOLD;
        HOLD:    if (diff) state_n = TRACK;
        default: state_n = IDLE;
      endcase
    end
  end

  assign commit      = (state == COMMIT) && enable && !freeze;
  assign changed_set = commit && (!valid || (prev != {snap_h, snap_w}));
  assign w1c         = bus.write && (bus.address == ADDR_STATUS) && bus.writedata[ST_CHANGED];
  assign ctrl_wr     = bus.write && (bus.address == ADDR_CTRL);

  // Width and height land on the same edge so a SNAP read is never torn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_w  <= '0;
      snap_h  <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      if (commit) begin
        snap_w <= prev[DW-1:0];
        snap_h <= prev[2*DW-1:DW];
        valid  <= 1'b1;
      end
      if (changed_set)  changed <= 1'b1;
      else if (w1c)     changed <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= 1'b0;
      freeze <= 1'b0;
    end else if (ctrl_wr) begin
      enable <= bus.writedata[CT_ENABLE];
      freeze <= bus.writedata[CT_FREEZE];
    end
  end

`ifdef RFS_DIM_CAPTURE_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= bus.writedata[CT_IRQ_EN];
      irq <= changed & irq_en;
    end
  end
  assign unused_bus = ^{bus.read, bus.writedata[31:3]};
`else
  assign irq_en     = 1'b0;
  assign unused_bus = ^{bus.read, bus.writedata[31:2]};
`endif

  always_comb begin
    rd_mux = '0;
    unique case (bus.address)
      ADDR_SNAP: begin
        rd_mux[DW-1:0]  = snap_w;
        rd_mux[16 +: DW] = snap_h;
      end
      ADDR_STATUS: begin
        rd_mux[ST_VALID]   = valid;
        rd_mux[ST_CHANGED] = changed;
        rd_mux[ST_BUSY]    = (state == TRACK);
      end
      ADDR_CTRL: begin
        rd_mux[CT_ENABLE] = enable;
        rd_mux[CT_FREEZE] = freeze;
        rd_mux[CT_IRQ_EN] = irq_en;
      end
      default: rd_mux[CNT_W-1:0] = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_mux;
  end

endmodule
